trap_arbiter: RTL and testbench

Trap arbiter directly upstream of the machine/supervisor cause CSRs. It collects synchronous exceptions from the commit stage and pending interrupts, and picks one trap by RISC-V priority. It resolves M/S delegation, flushes the pipeline, and then issues a one-cycle `trap_target_m`/`trap_target_s` pulse with a stable 64-bit `trap_cause`. The cause CSR block and the epc/tval CSRs consume that pulse.

---
 rtl/trap_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_trap_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_arbiter.sv
// -----------------------------------------------------------------------------
// trap_arbiter
//
// Picks one trap per event from the committing instruction's exceptions and the
// pending interrupts, resolves M/S delegation, holds the pipeline in a flush
// until it drains, then issues a single-cycle commit pulse towards the M or S
// cause CSRs.  Cause, epc and tval are captured when the trap is accepted and
// held stable until the next accepted trap.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   priv                current privilege (0=U, 1=S, 3=M)
//   mstatus_mie/sie     global interrupt enables
//   medeleg, mideleg    delegation masks (bits [15:0] used)
//   mip, mie            interrupt pending / enable (bits [11:0] used)
//   commit_valid        instruction at commit this cycle
//   exc_vec             one bit per exception cause raised at commit
//   commit_pc, exc_tval epc / tval source values
//   pipe_idle           pipeline drained after flush
//   flush_req           pipeline flush request (high while draining)
//   busy                arbiter is handling a trap
//   trap_cause          {interrupt, 59'b0, code}
//   trap_pc, trap_tval  captured epc / tval
//   trap_target_m/_s    one-cycle commit pulse, mutually exclusive
// -----------------------------------------------------------------------------
module trap_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  priv,
  input  logic        mstatus_mie,
  input  logic        mstatus_sie,
  input  logic [63:0] medeleg,
  input  logic [63:0] mideleg,
  input  logic [63:0] mip,
  input  logic [63:0] mie,
  input  logic        commit_valid,
  input  logic [15:0] exc_vec,
  input  logic [63:0] commit_pc,
  input  logic [63:0] exc_tval,
  input  logic        pipe_idle,
  output logic        flush_req,
  output logic        busy,
  output logic [63:0] trap_cause,
  output logic [63:0] trap_pc,
  output logic [63:0] trap_tval,
  output logic        trap_target_m,
  output logic        trap_target_s
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       tgt_s;
    logic [3:0] code;
  } sel_t;

  state_t state, state_nxt;
  logic   tgt_s_q;
  sel_t   irq_sel, exc_sel;
  logic   take;

  // Only the architecturally defined low bits of the CSR images matter here.
  logic unused_hi;
  assign unused_hi = ^{medeleg[63:16], mideleg[63:16], mip[63:12], mie[63:12]};

  // Interrupt codes in descending priority: MEI, MSI, MTI, SEI, SSI, STI.
  function automatic logic [3:0] irq_rank_code(input int rank);
    case (rank)
      0:       return 4'd11;
      1:       return 4'd3;
      2:       return 4'd7;
      3:       return 4'd9;
      4:       return 4'd1;
      default: return 4'd5;
    endcase
  endfunction

  // Exception codes in descending priority.  Codes 9, 10, 11 and 14 never
  // appear, so those exc_vec bits are ignored by construction (ecall is
  // always reported on bit 8 and remapped afterwards).
  function automatic logic [3:0] exc_rank_code(input int rank);
    case (rank)
      0:       return 4'd12;
      1:       return 4'd1;
      2:       return 4'd2;
      3:       return 4'd0;
      4:       return 4'd8;
      5:       return 4'd3;
      6:       return 4'd6;
      7:       return 4'd4;
      8:       return 4'd15;
      9:       return 4'd13;
      10:      return 4'd7;
      default: return 4'd5;
    endcase
  endfunction

  // Walk from lowest to highest priority so the highest takeable candidate
  // is the one left standing.
  function automatic sel_t pick_irq(input logic [15:0] pend,
                                    input logic [15:0] deleg,
                                    input logic [1:0]  p,
                                    input logic        m_en,
                                    input logic        s_en);
    sel_t       r;
    logic [3:0] c;
    logic       ok;
    r = '0;
    for (int k = 5; k >= 0; k--) begin
      c = irq_rank_code(k);
      if (deleg[c]) begin
        // S-targeted: never interrupts M, needs SIE while in S.
        ok = (p == 2'd0) || ((p == 2'd1) && s_en);
      end else begin
        // M-targeted: always preempts lower modes, needs MIE while in M.
        ok = (p != 2'd3) || m_en;
      end
      if (pend[c] && ok) begin
        r.hit   = 1'b1;
        r.tgt_s = deleg[c];
        r.code  = c;
      end
    end
    return r;
  endfunction

  function automatic sel_t pick_exc(input logic [15:0] ev,
                                    input logic [15:0] deleg,
                                    input logic [1:0]  p);
    sel_t       r;
    logic [3:0] c;
    r = '0;
    for (int k = 11; k >= 0; k--) begin
      c = exc_rank_code(k);
      if (ev[c]) begin
        r.hit  = 1'b1;
        r.code = c;
      end
    end
    // ecall: code depends on the mode it was issued from (8/9/11).
    if (r.hit && (r.code == 4'd8)) begin
      r.code = {2'b10, p};
    end
    // Exceptions raised in M are never delegated.
    r.tgt_s = r.hit && (p != 2'd3) && deleg[r.code];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Selection (combinational, evaluated only while IDLE)
  // ---------------------------------------------------------------------------
  always_comb begin
    irq_sel = pick_irq({4'b0, mip[11:0] & mie[11:0]}, mideleg[15:0], priv,
                       mstatus_mie, mstatus_sie);
    exc_sel = pick_exc(commit_valid ? exc_vec : 16'h0000, medeleg[15:0], priv);
  end

  assign take = (state == IDLE) && (irq_sel.hit || exc_sel.hit);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = DRAIN;
      DRAIN:   if (pipe_idle) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered control outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      flush_req     <= 1'b0;
      busy          <= 1'b0;
      trap_target_m <= 1'b0;
      trap_target_s <= 1'b0;
    end else begin
      state         <= state_nxt;
      flush_req     <= (state_nxt == DRAIN);
      busy          <= (state_nxt != IDLE);
      // COMMIT is only reachable through DRAIN, so tgt_s_q is already valid.
      trap_target_m <= (state_nxt == COMMIT) && !tgt_s_q;
      trap_target_s <= (state_nxt == COMMIT) &&  tgt_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Trap capture; an interrupt beats an exception raised in the same cycle
  // because the instruction re-executes after the handler returns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_cause <= '0;
      trap_pc    <= '0;
      trap_tval  <= '0;
      tgt_s_q    <= 1'b0;
    end else if (take) begin
      trap_pc <= commit_pc;
      if (irq_sel.hit) begin
        trap_cause <= {1'b1, 59'b0, irq_sel.code};
        trap_tval  <= '0;
        tgt_s_q    <= irq_sel.tgt_s;
      end else begin
        trap_cause <= {1'b0, 59'b0, exc_sel.code};
        trap_tval  <= exc_tval;
        tgt_s_q    <= exc_sel.tgt_s;
      end
    end
  end

endmodule

// File: tb/tb_trap_arbiter.sv
module tb_trap_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  priv;
  logic        mstatus_mie, mstatus_sie;
  logic [63:0] medeleg, mideleg, mip, mie;
  logic        commit_valid;
  logic [15:0] exc_vec;
  logic [63:0] commit_pc, exc_tval;
  logic        pipe_idle;
  logic        flush_req, busy;
  logic [63:0] trap_cause, trap_pc, trap_tval;
  logic        trap_target_m, trap_target_s;

  int checks = 0;
  int errors = 0;
  logic [63:0] held_cause = '0, held_pc = '0, held_tval = '0;

  int irq_order [6]  = '{11, 3, 7, 9, 1, 5};
  int exc_order [12] = '{12, 1, 2, 0, 8, 3, 6, 4, 15, 13, 7, 5};

  typedef struct {
    logic        hit;
    logic        s;
    logic [63:0] cause;
    logic [63:0] tval;
  } exp_t;

  trap_arbiter dut (
    .clk(clk), .rst(rst), .priv(priv),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
    .medeleg(medeleg), .mideleg(mideleg), .mip(mip), .mie(mie),
    .commit_valid(commit_valid), .exc_vec(exc_vec),
    .commit_pc(commit_pc), .exc_tval(exc_tval), .pipe_idle(pipe_idle),
    .flush_req(flush_req), .busy(busy),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .trap_target_m(trap_target_m), .trap_target_s(trap_target_s)
  );

  // Reference: first takeable interrupt in priority order, else first raised
  // exception in priority order.
  function automatic exp_t ref_model();
    exp_t e;
    e.hit = 1'b0; e.s = 1'b0; e.cause = '0; e.tval = '0;
    for (int i = 0; i < 6; i++) begin
      int b = irq_order[i];
      bit ok;
      if (mip[b] && mie[b]) begin
        if (mideleg[b]) ok = (priv == 0) || (priv == 1 && mstatus_sie);
        else            ok = (priv != 3) || mstatus_mie;
        if (ok) begin
          e.hit = 1'b1; e.s = mideleg[b];
          e.cause = 64'h8000_0000_0000_0000 | 64'(b);
          return e;
        end
      end
    end
    if (commit_valid) begin
      for (int i = 0; i < 12; i++) begin
        int c = exc_order[i];
        if (exc_vec[c]) begin
          if (c == 8) c = 8 + int'(priv);
          e.hit = 1'b1; e.cause = 64'(c); e.tval = exc_tval;
          e.s = (priv != 3) && medeleg[c];
          return e;
        end
      end
    end
    return e;
  endfunction

  task automatic clear_inputs();
    commit_valid = 1'b0; exc_vec = '0; mip = '0; mie = '0; pipe_idle = 1'b1;
  endtask

  task automatic set_ctx(input logic [1:0] p, input logic m_en, input logic s_en,
                         input logic [63:0] ed, input logic [63:0] id);
    priv = p; mstatus_mie = m_en; mstatus_sie = s_en; medeleg = ed; mideleg = id;
  endtask

  task automatic randomize_events();
    case ($urandom_range(0, 2))
      0:       priv = 2'd0;
      1:       priv = 2'd1;
      default: priv = 2'd3;
    endcase
    mstatus_mie  = 1'($urandom);
    mstatus_sie  = 1'($urandom);
    mip          = {52'b0, 12'($urandom)};
    mie          = {52'b0, 12'($urandom)};
    commit_valid = 1'($urandom);
    exc_vec      = 16'($urandom);
    commit_pc    = {$urandom, $urandom};
    exc_tval     = {$urandom, $urandom};
  endtask

  // Presents the currently driven inputs at the next edge and follows the
  // trap (if any) through DRAIN and COMMIT, injecting noise events meanwhile.
  task automatic fire(input string name, input logic e_hit, input logic e_s,
                      input logic [63:0] e_cause, input logic [63:0] e_tval,
                      input int drain_n);
    logic [63:0] e_pc;
    e_pc = commit_pc;
    @(posedge clk); #1;
    checks++;
    if (busy !== e_hit || flush_req !== e_hit) begin
      errors++;
      $display("FAIL %s accept: busy=%b flush=%b want %b", name, busy, flush_req, e_hit);
    end
    if (!e_hit) begin
      checks++;
      if (trap_cause !== held_cause || trap_pc !== held_pc || trap_tval !== held_tval) begin
        errors++;
        $display("FAIL %s hold: cause=%h pc=%h tval=%h want %h %h %h", name,
                 trap_cause, trap_pc, trap_tval, held_cause, held_pc, held_tval);
      end
      @(negedge clk); clear_inputs();
      return;
    end
    checks++;
    if (trap_cause !== e_cause || trap_pc !== e_pc || trap_tval !== e_tval) begin
      errors++;
      $display("FAIL %s capture: cause=%h pc=%h tval=%h want %h %h %h", name,
               trap_cause, trap_pc, trap_tval, e_cause, e_pc, e_tval);
    end
    checks++;
    if (trap_target_m !== 1'b0 || trap_target_s !== 1'b0) begin
      errors++;
      $display("FAIL %s early_pulse: m=%b s=%b want 0 0", name, trap_target_m, trap_target_s);
    end
    for (int k = 0; k < drain_n; k++) begin
      @(negedge clk); randomize_events(); pipe_idle = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (flush_req !== 1'b1 || busy !== 1'b1 || trap_target_m !== 1'b0 ||
          trap_target_s !== 1'b0 || trap_cause !== e_cause || trap_pc !== e_pc) begin
        errors++;
        $display("FAIL %s drain%0d: flush=%b busy=%b m=%b s=%b cause=%h want 1 1 0 0 %h",
                 name, k, flush_req, busy, trap_target_m, trap_target_s, trap_cause, e_cause);
      end
    end
    @(negedge clk); randomize_events(); pipe_idle = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (trap_target_m !== !e_s || trap_target_s !== e_s || flush_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s pulse: m=%b s=%b flush=%b busy=%b want %b %b 0 1", name,
               trap_target_m, trap_target_s, flush_req, busy, !e_s, e_s);
    end
    checks++;
    if (trap_cause !== e_cause || trap_pc !== e_pc || trap_tval !== e_tval) begin
      errors++;
      $display("FAIL %s commit_hold: cause=%h pc=%h tval=%h want %h %h %h", name,
               trap_cause, trap_pc, trap_tval, e_cause, e_pc, e_tval);
    end
    // Noise is still applied here: an event seen in COMMIT must be dropped.
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || flush_req !== 1'b0 || trap_target_m !== 1'b0 ||
        trap_target_s !== 1'b0 || trap_cause !== e_cause) begin
      errors++;
      $display("FAIL %s return_idle: busy=%b flush=%b m=%b s=%b cause=%h want 0 0 0 0 %h",
               name, busy, flush_req, trap_target_m, trap_target_s, trap_cause, e_cause);
    end
    held_cause = e_cause; held_pc = e_pc; held_tval = e_tval;
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    set_ctx(2'd0, 1'b0, 1'b0, '0, '0);
    commit_pc = '0; exc_tval = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({flush_req, busy, trap_target_m, trap_target_s} !== 4'b0 ||
        trap_cause !== '0 || trap_pc !== '0 || trap_tval !== '0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b cause=%h pc=%h tval=%h want 0",
               {flush_req, busy, trap_target_m, trap_target_s}, trap_cause, trap_pc, trap_tval);
    end
    @(negedge clk); rst = 1'b1;
    commit_valid = 1'b1; exc_vec = 16'h0004; commit_pc = 64'h1000; exc_tval = 64'hBEEF;
    pipe_idle = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || flush_req !== 1'b1 || trap_cause !== 64'd2) begin
      errors++;
      $display("FAIL reset_pre_drain: busy=%b flush=%b cause=%h want 1 1 2", busy, flush_req, trap_cause);
    end
    @(negedge clk); clear_inputs(); pipe_idle = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({flush_req, busy, trap_target_m, trap_target_s} !== 4'b0 ||
        trap_cause !== '0 || trap_pc !== '0 || trap_tval !== '0) begin
      errors++;
      $display("FAIL reset_async: ctl=%b cause=%h pc=%h tval=%h want 0",
               {flush_req, busy, trap_target_m, trap_target_s}, trap_cause, trap_pc, trap_tval);
    end
    @(negedge clk); rst = 1'b1; pipe_idle = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({flush_req, busy, trap_target_m, trap_target_s} !== 4'b0) begin
        errors++;
        $display("FAIL reset_no_pulse%0d: ctl=%b want 0000", k,
                 {flush_req, busy, trap_target_m, trap_target_s});
      end
    end
    held_cause = '0; held_pc = '0; held_tval = '0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    set_ctx(2'd0, 1'b0, 1'b0, '0, '0);
    commit_valid = 1'b1; exc_vec = 16'h0004; commit_pc = 64'h8000_0100; exc_tval = 64'hDEAD;
    fire("illegal", 1'b1, 1'b0, 64'd2, 64'hDEAD, 0);
  endtask

  task automatic test_ecall();
    set_ctx(2'd0, 1'b0, 1'b0, 64'h0100, '0);
    commit_valid = 1'b1; exc_vec = 16'h0100; commit_pc = 64'h2000; exc_tval = 64'h55;
    fire("ecall_u", 1'b1, 1'b1, 64'd8, 64'h55, 0);
    set_ctx(2'd3, 1'b0, 1'b0, 64'h0100, '0);
    commit_valid = 1'b1; exc_vec = 16'h0100; commit_pc = 64'h2004; exc_tval = 64'h0;
    fire("ecall_m", 1'b1, 1'b0, 64'd11, 64'h0, 0);
    set_ctx(2'd1, 1'b0, 1'b0, 64'h0200, '0);
    commit_valid = 1'b1; exc_vec = 16'h0100; commit_pc = 64'h2008; exc_tval = 64'h7;
    fire("ecall_s", 1'b1, 1'b1, 64'd9, 64'h7, 1);
  endtask

  task automatic test_exc_priority();
    set_ctx(2'd3, 1'b0, 1'b0, '0, '0);
    commit_valid = 1'b1; exc_vec = 16'h1004; commit_pc = 64'h3000; exc_tval = 64'hA1;
    fire("prio_12_over_2", 1'b1, 1'b0, 64'd12, 64'hA1, 0);
    commit_valid = 1'b1; exc_vec = 16'h0060; commit_pc = 64'h3004; exc_tval = 64'hA2;
    fire("prio_6_over_5", 1'b1, 1'b0, 64'd6, 64'hA2, 0);
    commit_valid = 1'b1; exc_vec = 16'h4E00; commit_pc = 64'h3008; exc_tval = 64'hA3;
    fire("ignored_bits", 1'b0, 1'b0, '0, '0, 0);
    commit_valid = 1'b0; exc_vec = 16'h0004; commit_pc = 64'h300C;
    fire("no_commit", 1'b0, 1'b0, '0, '0, 0);
  endtask

  task automatic test_irq_vs_exc();
    set_ctx(2'd3, 1'b1, 1'b0, '0, '0);
    mip = 64'h888; mie = 64'h888;
    commit_valid = 1'b1; exc_vec = 16'h0004; commit_pc = 64'h4000; exc_tval = 64'h1234;
    fire("irq_beats_exc", 1'b1, 1'b0, 64'h8000_0000_0000_000B, 64'h0, 0);
  endtask

  task automatic test_masking();
    set_ctx(2'd3, 1'b1, 1'b1, '0, 64'h200);
    mip = 64'h200; mie = 64'h200; commit_pc = 64'h5000;
    fire("sei_in_m", 1'b0, 1'b0, '0, '0, 0);
    set_ctx(2'd0, 1'b0, 1'b0, '0, 64'h200);
    mip = 64'h200; mie = 64'h200; commit_pc = 64'h5004;
    fire("sei_in_u", 1'b1, 1'b1, 64'h8000_0000_0000_0009, 64'h0, 0);
    set_ctx(2'd1, 1'b1, 1'b0, '0, 64'h200);
    mip = 64'h200; mie = 64'h200; commit_pc = 64'h5008;
    fire("sei_in_s_sie0", 1'b0, 1'b0, '0, '0, 0);
    set_ctx(2'd3, 1'b0, 1'b1, '0, '0);
    mip = 64'h80; mie = 64'h80; commit_pc = 64'h500C;
    fire("mti_in_m_mie0", 1'b0, 1'b0, '0, '0, 0);
    set_ctx(2'd1, 1'b0, 1'b0, '0, '0);
    mip = 64'h80; mie = 64'h80; commit_pc = 64'h5010;
    fire("mti_in_s", 1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h0, 0);
  endtask

  task automatic test_drain_wait();
    set_ctx(2'd0, 1'b0, 1'b0, '0, '0);
    commit_valid = 1'b1; exc_vec = 16'h0004; commit_pc = 64'h6000; exc_tval = 64'hDEAD;
    fire("drain5", 1'b1, 1'b0, 64'd2, 64'hDEAD, 5);
  endtask

  task automatic test_back_to_back();
    set_ctx(2'd1, 1'b0, 1'b0, 64'h0020, '0);
    commit_valid = 1'b1; exc_vec = 16'h0020; commit_pc = 64'h7000; exc_tval = 64'h11;
    fire("b2b_first", 1'b1, 1'b1, 64'd5, 64'h11, 0);
    set_ctx(2'd1, 1'b0, 1'b0, '0, '0);
    commit_valid = 1'b1; exc_vec = 16'h0001; commit_pc = 64'h7004; exc_tval = 64'h22;
    fire("b2b_second", 1'b1, 1'b0, 64'd0, 64'h22, 0);
  endtask

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 60; n++) begin
      randomize_events();
      medeleg = {48'b0, 16'($urandom)};
      mideleg = {48'b0, 16'($urandom)};
      if ($urandom_range(0, 2) == 0) mip = '0;
      pipe_idle = 1'b1;
      e = ref_model();
      fire("random", e.hit, e.s, e.cause, e.tval, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_ecall();
    test_exc_priority();
    test_irq_vs_exc();
    test_masking();
    test_drain_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
